// File: rtl/player_motion_ctrl.sv
// rtl/player_motion_ctrl.sv - 2-axis fixed-point player motion engine with bounds clamp, collision stun and pause
module player_motion_ctrl #(
    parameter int POS_W        = 11,
    parameter int FP_SHIFT     = 6,
    parameter int INITIAL_X    = 280,
    parameter int INITIAL_Y    = 185,
    parameter int X_MIN        = 10,
    parameter int X_MAX        = 556,
    parameter int Y_MIN        = 0,
    parameter int Y_MAX        = 440,
    parameter int ACCEL        = 16,
    parameter int MAX_SPEED    = 128,
    parameter int KNOCK_FRAMES = 4,
    parameter int ENABLE_Y     = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    startOfFrame,
    input  logic                    moveLeft,
    input  logic                    moveRight,
    input  logic                    moveUp,
    input  logic                    moveDown,
    input  logic                    collision,
    input  logic [3:0]              HitEdgeCode,
    input  logic                    pause,
    output logic signed [POS_W-1:0] topLeftX,
    output logic signed [POS_W-1:0] topLeftY,
    output logic                    moving,
    output logic                    stunned
);
    localparam int PW = POS_W + FP_SHIFT + 1;
    localparam int SW = PW + 2;
    localparam int CW = (KNOCK_FRAMES > 1) ? $clog2(KNOCK_FRAMES + 1) : 1;

    localparam logic signed [PW-1:0] X0   = PW'(INITIAL_X << FP_SHIFT);
    localparam logic signed [PW-1:0] Y0   = PW'(INITIAL_Y << FP_SHIFT);
    localparam logic signed [SW-1:0] XLO  = SW'(X_MIN << FP_SHIFT);
    localparam logic signed [SW-1:0] XHI  = SW'(X_MAX << FP_SHIFT);
    localparam logic signed [SW-1:0] YLO  = SW'(Y_MIN << FP_SHIFT);
    localparam logic signed [SW-1:0] YHI  = SW'(Y_MAX << FP_SHIFT);
    localparam logic signed [SW-1:0] ACC1 = SW'(ACCEL);
    localparam logic signed [SW-1:0] ACC2 = SW'(2 * ACCEL);
    localparam logic signed [SW-1:0] VMAX = SW'(MAX_SPEED);
    localparam logic [CW-1:0]        KNOCK = CW'(KNOCK_FRAMES);
    localparam logic [CW-1:0]        ONE   = CW'(1);

    typedef enum logic {RUN, STUN} state_t;

    state_t               state;
    logic signed [PW-1:0] pos_x, pos_y, prev_x, prev_y, spd_x, spd_y;
    logic [CW-1:0]        cnt;
    logic                 col_q;
    logic [3:0]           hit_q;

    logic signed [1:0]    dir_x, dir_y;
    logic signed [PW-1:0] acc_x, acc_y, spd_x_n, spd_y_n, pos_x_n, pos_y_n;
    logic [PW:0]          px_r, py_r;
    logic                 commit, eff_col, hit_x, hit_y;
    logic [3:0]           eff_hit;

    function automatic logic signed [SW-1:0] toward_zero(input logic signed [SW-1:0] s,
                                                         input logic signed [SW-1:0] step);
        logic signed [SW-1:0] r;
        r = '0;
        if (s > step)
            r = s - step;
        else if (s < -step)
            r = s + step;
        return r;
    endfunction

    function automatic logic signed [PW-1:0] next_speed(input logic signed [PW-1:0] s,
                                                        input logic signed [1:0]    d);
        logic signed [SW-1:0] w;
        w = SW'(s);
        if (d == 2'sd0)
            w = toward_zero(w, ACC1);
        else if (d[1] != s[PW-1] && s != '0)
            w = toward_zero(w, ACC2);   // reversal brakes twice as hard
        else begin
            w = d[1] ? w - ACC1 : w + ACC1;
            if (w > VMAX)
                w = VMAX;
            else if (w < -VMAX)
                w = -VMAX;
        end
        return PW'(w);
    endfunction

    // Returns {clamped, new position}
    function automatic logic [PW:0] next_pos(input logic signed [PW-1:0] p,
                                             input logic signed [PW-1:0] v,
                                             input logic signed [SW-1:0] lo,
                                             input logic signed [SW-1:0] hi);
        logic signed [SW-1:0] sum;
        logic [PW:0]          r;
        sum = SW'(p) + SW'(v);
        if (sum < lo)
            r = {1'b1, lo[PW-1:0]};
        else if (sum > hi)
            r = {1'b1, hi[PW-1:0]};
        else
            r = {1'b0, sum[PW-1:0]};
        return r;
    endfunction

    always_comb begin
        dir_x = 2'sd0;
        dir_y = 2'sd0;
        if (state == RUN) begin
            if (moveRight && !moveLeft)
                dir_x = 2'sd1;
            else if (moveLeft && !moveRight)
                dir_x = -2'sd1;
            if (moveDown && !moveUp)
                dir_y = 2'sd1;
            else if (moveUp && !moveDown)
                dir_y = -2'sd1;
        end

        acc_x   = next_speed(spd_x, dir_x);
        px_r    = next_pos(pos_x, acc_x, XLO, XHI);
        pos_x_n = px_r[PW-1:0];
        spd_x_n = px_r[PW] ? '0 : acc_x;

        acc_y   = next_speed(spd_y, dir_y);
        py_r    = next_pos(pos_y, acc_y, YLO, YHI);
        pos_y_n = py_r[PW-1:0];
        spd_y_n = py_r[PW] ? '0 : acc_y;
        if (ENABLE_Y == 0) begin
            pos_y_n = pos_y;
            spd_y_n = '0;
        end

        // A collision on the committing cycle itself belongs to the frame being closed
        commit  = startOfFrame && !pause;
        eff_col = col_q || collision;
        eff_hit = hit_q | (collision ? HitEdgeCode : 4'b0000);
        hit_x   = eff_hit[1] || eff_hit[3] || (eff_hit == 4'b0000);
        hit_y   = eff_hit[0] || eff_hit[2] || (eff_hit == 4'b0000);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= RUN;
            pos_x  <= X0;
            pos_y  <= Y0;
            prev_x <= X0;
            prev_y <= Y0;
            spd_x  <= '0;
            spd_y  <= '0;
            cnt    <= '0;
            col_q  <= 1'b0;
            hit_q  <= 4'b0000;
        end else begin
            if (collision) begin
                col_q <= 1'b1;
                hit_q <= hit_q | HitEdgeCode;
            end
            if (commit) begin
                col_q  <= 1'b0;
                hit_q  <= 4'b0000;
                prev_x <= pos_x;
                prev_y <= pos_y;
                if (state == RUN && eff_col) begin
                    pos_x <= prev_x;
                    pos_y <= prev_y;
                    if (hit_x)
                        spd_x <= '0;
                    if (hit_y)
                        spd_y <= '0;
                    cnt   <= KNOCK;
                    state <= STUN;
                end else begin
                    pos_x <= pos_x_n;
                    pos_y <= pos_y_n;
                    spd_x <= spd_x_n;
                    spd_y <= spd_y_n;
                    if (state == STUN) begin
                        if (eff_col)
                            cnt <= KNOCK;
                        else if (cnt == ONE) begin
                            cnt   <= '0;
                            state <= RUN;
                        end else
                            cnt <= cnt - ONE;
                    end
                end
            end
        end
    end

    assign topLeftX = pos_x[FP_SHIFT +: POS_W];
    assign topLeftY = pos_y[FP_SHIFT +: POS_W];
    assign moving   = (spd_x != '0) || (spd_y != '0);
    assign stunned  = (state == STUN);

endmodule
